// File: rtl/priority_code_decoder_pkg.sv
// Shared definitions for the priority code decoder: code widths, FSM states, code-to-line mapping.
// Latency: n/a (constants, types and a pure combinational helper).
// Backpressure: n/a.
package priority_code_pkg;

  localparam int CODE_W = 4;
  localparam int LINES  = 8;

  localparam logic [CODE_W-1:0] CODE_NONE = 4'd0;
  localparam logic [CODE_W-1:0] CODE_MAX  = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Code c in 1..8 selects line c-1; anything else maps to no line.
  function automatic logic [LINES-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [LINES-1:0] r;
    r = '0;
    if (code != CODE_NONE && code <= CODE_MAX) begin
      r = LINES'(1) << (code - 4'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/priority_code_decoder_code_fifo.sv
// Synchronous FIFO buffering accepted priority codes ahead of the pulse FSM.
// Latency: a pushed entry is visible at dout/empty one cycle after the push edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read side (dout is the
//        head entry, valid whenever empty is low), full, empty.
module code_fifo
  import priority_code_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/priority_code_decoder.sv
// Replays buffered 4-bit priority codes as stretched, non-overlapping one-hot pulses.
// Latency: code accepted at edge N into an idle, empty block drives out_onehot from edge N+1.
// Backpressure: code_ready = !fifo_full (low during reset); illegal/zero codes are dropped.
// Ports: clk, rst (async, active-high); code_in/code_valid/code_ready input handshake;
//        out_onehot (registered pulse), out_active (pulse in progress), busy, err.
// Build option: PRIORITY_DECODE_STICKY_ERR_EN makes err hold until reset instead of pulsing.
module priority_code_decoder
  import priority_code_pkg::*;
#(
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [LINES-1:0]  out_onehot,
  output logic              out_active,
  output logic              busy,
  output logic              err
);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;
  logic [LINES-1:0]  onehot_nxt;
  logic [CODE_W-1:0] head_code;
  logic              fifo_full;
  logic              fifo_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              illegal;

  assign code_ready = !rst && !fifo_full;
  assign accept     = code_valid && code_ready;
  assign push       = accept && (code_in != CODE_NONE) && (code_in <= CODE_MAX);
  assign illegal    = accept && (code_in > CODE_MAX);
  assign pop        = (state == IDLE) && !fifo_empty;

  assign out_active = (state == PULSE);
  assign busy       = (state != IDLE) || !fifo_empty;

  code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (code_in),
    .pop   (pop),
    .dout  (head_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_onehot <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_onehot <= onehot_nxt;
    end
  end

  // cnt counts down the remaining cycles of the current PULSE or GAP phase.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    onehot_nxt = out_onehot;
    case (state)
      IDLE: begin
        onehot_nxt = '0;
        if (!fifo_empty) begin
          onehot_nxt = code_to_onehot(head_code);
          cnt_nxt    = 8'(PULSE_LEN - 1);
          state_nxt  = PULSE;
        end
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          onehot_nxt = '0;
          if (GAP_LEN > 0) begin
            cnt_nxt   = 8'(GAP_LEN - 1);
            state_nxt = GAP;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      GAP: begin
        onehot_nxt = '0;
        if (cnt == 8'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: begin
        onehot_nxt = '0;
        cnt_nxt    = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
`ifdef PRIORITY_DECODE_STICKY_ERR_EN
      err <= err | illegal;
`else
      err <= illegal;
`endif
    end
  end

endmodule

// File: tb/tb_priority_code_decoder.sv
module tb_priority_code_decoder;

  localparam int P     = 4;
  localparam int G     = 1;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic [3:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] out_onehot;
  logic       out_active;
  logic       busy;
  logic       err;

  logic [3:0] f_code_in;
  logic       f_code_valid;
  logic       f_code_ready;
  logic [7:0] f_out_onehot;
  logic       f_out_active;
  logic       f_busy;
  logic       f_err;

  priority_code_decoder #(.PULSE_LEN(P), .GAP_LEN(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .code_ready(code_ready), .out_onehot(out_onehot), .out_active(out_active),
    .busy(busy), .err(err)
  );

  priority_code_decoder #(.PULSE_LEN(1), .GAP_LEN(0), .FIFO_DEPTH(4)) dut_fast (
    .clk(clk), .rst(rst), .code_in(f_code_in), .code_valid(f_code_valid),
    .code_ready(f_code_ready), .out_onehot(f_out_onehot), .out_active(f_out_active),
    .busy(f_busy), .err(f_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  // Each legal code accepted at edge acc is popped at edge pop = max(acc+1, next_free);
  // it shows on the output for cycles pop..pop+P-1, the block is busy from acc through
  // pop+P+G-1, and the following pop can happen no earlier than pop+P+G+1.
  typedef struct {
    int         acc;
    int         pop;
    logic [3:0] code;
  } ent_t;

  ent_t ent_q[$];
  int   err_q[$];
  int   next_free;
  int   cyc;
  int   legal_acc;
  int   pulses_seen;
  logic prev_act;
  logic saw_block;

  task automatic model_clear();
    ent_q.delete();
    err_q.delete();
    next_free = 0;
    cyc       = 0;
    prev_act  = 1'b0;
  endtask

  function automatic int occ(input int k);
    int n;
    n = 0;
    foreach (ent_q[i]) if (ent_q[i].acc <= k && ent_q[i].pop > k) n++;
    return n;
  endfunction

  function automatic logic [7:0] exp_onehot(input int k);
    foreach (ent_q[i])
      if (ent_q[i].pop <= k && k <= ent_q[i].pop + P - 1)
        return 8'(1) << (ent_q[i].code - 4'd1);
    return 8'h00;
  endfunction

  function automatic logic exp_busy(input int k);
    foreach (ent_q[i])
      if (ent_q[i].acc <= k && k <= ent_q[i].pop + P + G - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_err(input int k);
    foreach (err_q[i]) begin
`ifdef PRIORITY_DECODE_STICKY_ERR_EN
      if (err_q[i] <= k) return 1'b1;
`else
      if (err_q[i] == k) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  task automatic accept_code(input logic [3:0] c, input int edge_n);
    ent_t e;
    if (c >= 4'd1 && c <= 4'd8) begin
      e.acc  = edge_n;
      e.pop  = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
      e.code = c;
      next_free = e.pop + P + G + 1;
      ent_q.push_back(e);
      legal_acc++;
    end else if (c > 4'd8) begin
      err_q.push_back(edge_n);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] eo;
    eo = exp_onehot(cyc);
    chk("out_onehot", out_onehot, eo);
    chk("out_active", out_active, eo != 8'h00);
    chk("busy", busy, exp_busy(cyc));
    chk("err", err, exp_err(cyc));
    if (out_active && !prev_act) pulses_seen++;
    prev_act = out_active;
  endtask

  // Drive one cycle of input, then check the state after the next edge.
  task automatic step(input logic v, input logic [3:0] c);
    logic er;
    code_valid = v;
    code_in    = c;
    #1;
    er = (occ(cyc) < DEPTH);
    chk("code_ready", code_ready, er);
    if (code_ready === 1'b0) saw_block = 1'b1;
    if (v && er) accept_code(c, cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
    code_valid = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    #2;
    rst          = 1'b1;
    code_valid   = 1'b0;
    f_code_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       v;
    logic [3:0] c;
    logic [7:0] exp_oh;
    logic       exp_busy;
  } vec_t;

  vec_t tab[8];

  typedef struct {
    logic [7:0] pattern;
    logic [3:0] code;
    logic [7:0] exp;
  } rt_t;

  rt_t rt_tab[256];

  initial begin
    // Single code 3 with default timing: 1 buffered cycle, 4 pulse cycles, GAP, IDLE.
    tab[0] = '{1'b1, 4'd3, 8'h00, 1'b1};
    tab[1] = '{1'b0, 4'd0, 8'h04, 1'b1};
    tab[2] = '{1'b0, 4'd0, 8'h04, 1'b1};
    tab[3] = '{1'b0, 4'd0, 8'h04, 1'b1};
    tab[4] = '{1'b0, 4'd0, 8'h04, 1'b1};
    tab[5] = '{1'b0, 4'd0, 8'h00, 1'b1};
    tab[6] = '{1'b0, 4'd0, 8'h00, 1'b0};
    tab[7] = '{1'b0, 4'd0, 8'h00, 1'b0};

    // Round trip through an 8-input priority encoder: expected pulse is the top set bit.
    for (int p = 0; p < 256; p++) begin
      logic [7:0] pat;
      logic [7:0] top;
      logic [3:0] cd;
      pat = 8'(p);
      cd  = 4'd0;
      for (int i = 0; i < 8; i++) if (pat[i]) cd = 4'(i + 1);
      top = 8'h00;
      for (int b = 7; b >= 0; b--) if (pat[b] && top == 8'h00) top = 8'(1) << b;
      rt_tab[p] = '{pat, cd, top};
    end

    rst          = 1'b1;
    code_valid   = 1'b0;
    code_in      = 4'd0;
    f_code_valid = 1'b0;
    f_code_in    = 4'd0;
    legal_acc    = 0;
    pulses_seen  = 0;
    saw_block    = 1'b0;
    model_clear();

    #2;
    chk("reset_onehot", out_onehot, 8'h00);
    chk("reset_active", out_active, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_ready", code_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      code_valid = tab[i].v;
      code_in    = tab[i].c;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      chk("tab_onehot", out_onehot, tab[i].exp_oh);
      chk("tab_busy", busy, tab[i].exp_busy);
    end

    for (int p = 0; p < 256; p++) begin
      f_code_valid = 1'b1;
      f_code_in    = rt_tab[p].code;
      @(posedge clk);
      #1;
      f_code_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("roundtrip_pulse", f_out_onehot, rt_tab[p].exp);
      @(posedge clk);
      #1;
      chk("roundtrip_clear", f_out_onehot, 8'h00);
    end

    // Back-to-back 8, 1, 5.
    do_reset();
    step(1'b1, 4'd8);
    step(1'b1, 4'd1);
    step(1'b1, 4'd5);
    repeat (25) step(1'b0, 4'd0);

    // Continuous code 2: FIFO fills, ready drops, every accepted code is pulsed once.
    do_reset();
    legal_acc   = 0;
    pulses_seen = 0;
    saw_block   = 1'b0;
    repeat (20) step(1'b1, 4'd2);
    repeat (45) step(1'b0, 4'd0);
    chk("hold_ready_dropped", saw_block, 1'b1);
    chk("hold_pulse_count", pulses_seen, legal_acc);

    // Zero and illegal codes.
    do_reset();
    step(1'b1, 4'd0);
    step(1'b0, 4'd0);
    step(1'b1, 4'd9);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    step(1'b1, 4'd15);
    repeat (3) step(1'b0, 4'd0);

    // Reset in the middle of a pulse with two codes still buffered.
    do_reset();
    step(1'b1, 4'd3);
    step(1'b1, 4'd4);
    step(1'b1, 4'd6);
    step(1'b0, 4'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_onehot", out_onehot, 8'h00);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_active", out_active, 1'b0);
    chk("midrst_ready", code_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (20) step(1'b0, 4'd0);

    // Random traffic against the timeline model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      logic       v;
      logic [3:0] c;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
      else                           c = 4'($urandom_range(1, 8));
      step(v, c);
    end
    repeat (40) step(1'b0, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
